dma_irq_coalescer: RTL and testbench

Interrupt coalescing stage that sits directly downstream of the DMA core wrapper's `irq_o` pulses and in front of the platform interrupt controller. It counts per-source completion pulses and raises a level interrupt only when a programmable event-count threshold or a cycle timeout is reached, which cuts interrupt load for streams of short transfers. It has its own register-interface configuration port, decoded from the same AXI-to-reg bridge style used by the DMA frontend.

---
 rtl/dma_irq_coalescer_pkg.sv | 49 ++++
 rtl/dma_irq_coalescer_chan.sv | 104 ++++++++++
 rtl/dma_irq_coalescer.sv | 127 ++++++++++++
 tb/tb_dma_irq_coalescer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_irq_coalescer_pkg.sv
// Shared definitions for the DMA interrupt coalescer: register map, FSM encoding,
// register-interface payloads and the byte-strobe merge helper.
package dma_irq_coalescer_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned RegStride = 8;

    localparam logic [AddrWidth-1:0] OffCtrl    = 32'h00;
    localparam logic [AddrWidth-1:0] OffThresh  = 32'h08;
    localparam logic [AddrWidth-1:0] OffTimeout = 32'h10;
    localparam logic [AddrWidth-1:0] OffStatus  = 32'h18;
    localparam logic [AddrWidth-1:0] OffAck     = 32'h20;
    localparam logic [AddrWidth-1:0] OffCnt0    = 32'h28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } fsm_e;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] wstrb;
        logic                 valid;
    } reg_req_s;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 error;
        logic                 ready;
    } reg_rsp_s;

    // Byte-lane merge of the low 32 data bits into an existing register value.
    function automatic logic [31:0] wr_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{wstrb[b]}};
        end
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/dma_irq_coalescer_chan.sv
// One interrupt source: IDLE/ACCUM/FIRE state machine with saturating event
// counter and timer; the interrupt level is a registered decode of the state.
module dma_irq_coalescer_chan
    import dma_irq_coalescer_pkg::*;
#(
    parameter int unsigned CntWidth   = 8,
    parameter int unsigned TimerWidth = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_dis,
    input  logic                  i_evt,
    input  logic                  i_ack,
    input  logic [CntWidth-1:0]   i_thresh,
    input  logic [TimerWidth-1:0] i_timeout,
    output logic                  o_irq,
    output logic [CntWidth-1:0]   o_cnt
);

    localparam logic [CntWidth-1:0]   CntMax   = '1;
    localparam logic [TimerWidth-1:0] TimerMax = '1;

    fsm_e                  r_state;
    fsm_e                  w_state_nxt;
    logic [CntWidth-1:0]   r_cnt;
    logic [CntWidth-1:0]   w_cnt_nxt;
    logic [CntWidth-1:0]   w_cnt_inc;
    logic [TimerWidth-1:0] r_timer;
    logic [TimerWidth-1:0] w_timer_nxt;
    logic [TimerWidth-1:0] w_timer_inc;
    logic                  r_irq;
    logic                  w_irq_nxt;

    assign w_cnt_inc   = (r_cnt == CntMax) ? r_cnt : r_cnt + CntWidth'(1);
    assign w_timer_inc = (r_timer == TimerMax) ? r_timer : r_timer + TimerWidth'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_timer <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    // Next state; a disable (current or being written this cycle) overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        if (!i_en || i_dis) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_evt) begin
                        w_cnt_nxt   = CntWidth'(1);
                        w_timer_nxt = '0;
                        w_state_nxt = (CntWidth'(1) >= i_thresh) ? FIRE : ACCUM;
                    end
                end
                ACCUM: begin
                    w_cnt_nxt   = i_evt ? w_cnt_inc : r_cnt;
                    w_timer_nxt = w_timer_inc;
                    if ((w_cnt_nxt >= i_thresh) ||
                        ((i_timeout != '0) && (w_timer_nxt >= i_timeout))) begin
                        w_state_nxt = FIRE;
                    end
                end
                FIRE: begin
                    if (i_ack) begin
                        w_state_nxt = i_evt ? ACCUM : IDLE;
                        w_cnt_nxt   = i_evt ? CntWidth'(1) : '0;
                        w_timer_nxt = '0;
                    end else if (i_evt) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_irq_nxt = 1'b0;
        w_irq_nxt = (r_state == FIRE) && i_en && !i_dis;
    end

    assign o_irq = r_irq;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/dma_irq_coalescer.sv
// Interrupt coalescer top: register decode, shared CTRL/THRESH/TIMEOUT registers
// and one coalescing channel per DMA completion source.
module dma_irq_coalescer
    import dma_irq_coalescer_pkg::*;
#(
    parameter int unsigned NumIrq     = 2,
    parameter int unsigned CntWidth   = 8,
    parameter int unsigned TimerWidth = 16,
    parameter type         reg_req_t  = reg_req_s,
    parameter type         reg_rsp_t  = reg_rsp_s
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumIrq-1:0] irq_i,
    input  reg_req_t          reg_req_i,
    output reg_rsp_t          reg_rsp_o,
    output logic [NumIrq-1:0] irq_o
);

    logic [NumIrq-1:0]     r_ctrl;
    logic [CntWidth-1:0]   r_thresh;
    logic [TimerWidth-1:0] r_timeout;

    logic [31:0]           w_rdata;
    logic                  w_err;
    logic                  w_ctrl_we;
    logic                  w_thresh_we;
    logic                  w_timeout_we;
    logic                  w_ack_we;
    logic [NumIrq-1:0]     w_ctrl_new;
    logic [CntWidth-1:0]   w_thresh_new;
    logic [TimerWidth-1:0] w_timeout_new;
    logic [NumIrq-1:0]     w_ack;
    logic [NumIrq-1:0]     w_dis;
    logic [CntWidth-1:0]   w_cnt [NumIrq];
    logic                  w_unused;

    assign w_ctrl_new    = NumIrq'(wr_merge(32'(r_ctrl), reg_req_i.wdata[31:0], reg_req_i.wstrb[3:0]));
    assign w_thresh_new  = CntWidth'(wr_merge(32'(r_thresh), reg_req_i.wdata[31:0], reg_req_i.wstrb[3:0]));
    assign w_timeout_new = TimerWidth'(wr_merge(32'(r_timeout), reg_req_i.wdata[31:0], reg_req_i.wstrb[3:0]));
    assign w_ack         = {NumIrq{w_ack_we}} &
                           NumIrq'(wr_merge(32'h0, reg_req_i.wdata[31:0], reg_req_i.wstrb[3:0]));
    assign w_dis         = {NumIrq{w_ctrl_we}} & ~w_ctrl_new;
    assign w_unused      = ^{reg_req_i.wdata[DataWidth-1:32], reg_req_i.wstrb[StrbWidth-1:4]};

    // Address decode; errors suppress every write strobe.
    always_comb begin
        w_rdata      = '0;
        w_err        = 1'b0;
        w_ctrl_we    = 1'b0;
        w_thresh_we  = 1'b0;
        w_timeout_we = 1'b0;
        w_ack_we     = 1'b0;
        if (reg_req_i.valid) begin
            case (reg_req_i.addr)
                OffCtrl: begin
                    w_rdata   = 32'(r_ctrl);
                    w_ctrl_we = reg_req_i.write;
                end
                OffThresh: begin
                    w_rdata     = 32'(r_thresh);
                    w_thresh_we = reg_req_i.write;
                end
                OffTimeout: begin
                    w_rdata      = 32'(r_timeout);
                    w_timeout_we = reg_req_i.write;
                end
                OffStatus: begin
                    w_rdata = 32'(irq_o);
                    w_err   = reg_req_i.write;
                end
                OffAck: begin
                    w_ack_we = reg_req_i.write;
                end
                default: begin
                    w_err = 1'b1;
                    for (int i = 0; i < NumIrq; i++) begin
                        if (reg_req_i.addr == OffCnt0 + AddrWidth'(RegStride * i)) begin
                            w_err = reg_req_i.write;
                            if (!reg_req_i.write) begin
                                w_rdata = 32'(w_cnt[i]);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = DataWidth'(w_rdata);
        reg_rsp_o.error = w_err;
        reg_rsp_o.ready = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl    <= '0;
            r_thresh  <= CntWidth'(1);
            r_timeout <= '0;
        end else begin
            if (w_ctrl_we)    r_ctrl    <= w_ctrl_new;
            if (w_thresh_we)  r_thresh  <= w_thresh_new;
            if (w_timeout_we) r_timeout <= w_timeout_new;
        end
    end

    for (genvar g = 0; g < NumIrq; g++) begin : g_chan
        dma_irq_coalescer_chan #(
            .CntWidth   (CntWidth),
            .TimerWidth (TimerWidth)
        ) u_chan (
            .i_clk     (clk_i),
            .i_rst_n   (rst_ni),
            .i_en      (r_ctrl[g]),
            .i_dis     (w_dis[g]),
            .i_evt     (irq_i[g]),
            .i_ack     (w_ack[g]),
            .i_thresh  (r_thresh),
            .i_timeout (r_timeout),
            .o_irq     (irq_o[g]),
            .o_cnt     (w_cnt[g])
        );
    end

endmodule

// File: tb/tb_dma_irq_coalescer.sv
// Scoreboard bench for dma_irq_coalescer: directed stimulus pushes expectations,
// a negedge monitor pops and compares register responses and irq_o probes.
module tb_dma_irq_coalescer;
    import dma_irq_coalescer_pkg::*;

    localparam int unsigned NumIrq = 2;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NumIrq-1:0] irq_i;
    logic [NumIrq-1:0] irq_o;
    reg_req_s          req;
    reg_rsp_s          rsp;
    logic              probe;

    int n_checks = 0;
    int n_fail   = 0;

    string             q_rsp_name[$];
    logic [63:0]       q_rsp_data[$];
    bit                q_rsp_chk[$];
    logic              q_rsp_err[$];
    string             q_irq_name[$];
    logic [NumIrq-1:0] q_irq_exp[$];

    string             m_name;
    logic [63:0]       m_data;
    bit                m_chk;
    logic              m_err;
    logic [NumIrq-1:0] m_irq;

    always #5 clk = ~clk;

    dma_irq_coalescer #(
        .NumIrq     (NumIrq),
        .CntWidth   (8),
        .TimerWidth (16)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .irq_i     (irq_i),
        .reg_req_i (req),
        .reg_rsp_o (rsp),
        .irq_o     (irq_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        req.valid = 1'b0;
        req.write = 1'b0;
        irq_i     = '0;
        probe     = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [63:0] d, input logic e, input string nm);
        q_rsp_name.push_back(nm);
        q_rsp_data.push_back(d);
        q_rsp_chk.push_back(!e);
        q_rsp_err.push_back(e);
        req.addr  = a;
        req.write = 1'b0;
        req.wdata = '0;
        req.wstrb = '1;
        req.valid = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic e, input string nm);
        q_rsp_name.push_back(nm);
        q_rsp_data.push_back(64'h0);
        q_rsp_chk.push_back(1'b0);
        q_rsp_err.push_back(e);
        req.addr  = a;
        req.write = 1'b1;
        req.wdata = 64'(d);
        req.wstrb = '1;
        req.valid = 1'b1;
    endtask

    task automatic expect_irq(input logic [NumIrq-1:0] x, input string nm);
        q_irq_name.push_back(nm);
        q_irq_exp.push_back(x);
        probe = 1'b1;
    endtask

    task automatic pulse(input logic [NumIrq-1:0] m);
        irq_i = m;
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (req.valid) begin
            n_checks++;
            if (q_rsp_name.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_queue_empty: response seen with no expectation");
            end else begin
                m_name = q_rsp_name.pop_front();
                m_data = q_rsp_data.pop_front();
                m_chk  = q_rsp_chk.pop_front();
                m_err  = q_rsp_err.pop_front();
                if (rsp.error !== m_err || rsp.ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s: got error=%0b ready=%0b, expected error=%0b ready=1",
                             m_name, rsp.error, rsp.ready, m_err);
                end
                if (m_chk) begin
                    n_checks++;
                    if (rsp.rdata !== m_data) begin
                        n_fail++;
                        $display("FAIL %s: got rdata=0x%0h, expected 0x%0h", m_name, rsp.rdata, m_data);
                    end
                end
            end
        end
        if (probe) begin
            n_checks++;
            if (q_irq_name.size() == 0) begin
                n_fail++;
                $display("FAIL irq_queue_empty: probe with no expectation");
            end else begin
                m_name = q_irq_name.pop_front();
                m_irq  = q_irq_exp.pop_front();
                if (irq_o !== m_irq) begin
                    n_fail++;
                    $display("FAIL %s: got irq_o=%b, expected %b", m_name, irq_o, m_irq);
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        req    = '0;
        irq_i  = '0;
        probe  = 1'b0;
        @(posedge clk); #1;
        expect_irq(2'b00, "irq_in_reset");
        tick(); tick();
        rst_ni = 1'b1;

        // Reset values
        rd(OffCtrl,    64'd0, 1'b0, "rst_ctrl");    tick();
        rd(OffThresh,  64'd1, 1'b0, "rst_thresh");  tick();
        rd(OffTimeout, 64'd0, 1'b0, "rst_timeout"); tick();
        rd(OffStatus,  64'd0, 1'b0, "rst_status");  expect_irq(2'b00, "rst_irq"); tick();
        rd(32'h28,     64'd0, 1'b0, "rst_cnt0");    tick();
        rd(32'h30,     64'd0, 1'b0, "rst_cnt1");    tick();

        // Threshold: 4 pulses, irq one cycle after the 4th, ACK clears
        wr(OffThresh, 32'd4, 1'b0, "wr_thresh4"); tick();
        wr(OffCtrl,   32'd1, 1'b0, "wr_ctrl1");   tick();
        for (int k = 0; k < 4; k++) begin
            pulse(2'b01);
            expect_irq(2'b00, "thr_accum");
            tick();
        end
        expect_irq(2'b00, "thr_fire_minus1"); rd(32'h28, 64'd4, 1'b0, "thr_cnt4"); tick();
        expect_irq(2'b01, "thr_fire");        rd(OffStatus, 64'd1, 1'b0, "thr_status"); tick();
        wr(OffAck, 32'd1, 1'b0, "thr_ack");   expect_irq(2'b01, "thr_ack_cycle"); tick();
        expect_irq(2'b01, "thr_ack_plus1");   rd(32'h28, 64'd0, 1'b0, "thr_cnt_cleared"); tick();
        expect_irq(2'b00, "thr_irq_low");     tick();

        // Timeout: THRESH unreachable, TIMEOUT=10, single pulse on source 1
        wr(OffThresh,  32'd200, 1'b0, "wr_thresh200"); tick();
        wr(OffTimeout, 32'd10,  1'b0, "wr_timeout10"); tick();
        wr(OffCtrl,    32'd3,   1'b0, "wr_ctrl3");     tick();
        pulse(2'b10); tick();
        for (int k = 1; k <= 11; k++) begin
            if (k == 5)  rd(32'h30, 64'd1, 1'b0, "to_cnt1");
            if (k == 11) expect_irq(2'b00, "to_before");
            tick();
        end
        expect_irq(2'b10, "to_fire"); wr(OffStatus, 32'hFFFF_FFFF, 1'b1, "wr_status_err"); tick();
        expect_irq(2'b10, "to_hold"); rd(OffStatus, 64'd2, 1'b0, "status_unchanged"); tick();
        wr(OffAck, 32'd2, 1'b0, "to_ack"); tick();
        tick();
        expect_irq(2'b00, "to_irq_low"); tick();

        // Immediate mode and saturation during FIRE
        wr(OffTimeout, 32'd0, 1'b0, "wr_timeout0"); tick();
        wr(OffThresh,  32'd0, 1'b0, "wr_thresh0");  tick();
        wr(OffCtrl,    32'd1, 1'b0, "wr_ctrl1b");   tick();
        pulse(2'b01); tick();
        for (int k = 1; k < 300; k++) begin
            pulse(2'b01);
            expect_irq((k == 1) ? 2'b00 : 2'b01, "imm_irq");
            tick();
        end
        rd(32'h28, 64'd255, 1'b0, "imm_cnt_sat"); expect_irq(2'b01, "imm_hold"); tick();

        // ACK collides with a pulse: back to ACCUM with cnt=1, refire after 2 more
        wr(OffThresh, 32'd3, 1'b0, "wr_thresh3"); expect_irq(2'b01, "col_pre"); tick();
        wr(OffAck, 32'd1, 1'b0, "col_ack"); pulse(2'b01); tick();
        expect_irq(2'b01, "col_ack_plus1"); rd(32'h28, 64'd1, 1'b0, "col_cnt1"); tick();
        expect_irq(2'b00, "col_irq_low"); rd(OffStatus, 64'd0, 1'b0, "col_status0"); tick();
        pulse(2'b01); expect_irq(2'b00, "col_p2"); tick();
        pulse(2'b01); expect_irq(2'b00, "col_p3"); tick();
        expect_irq(2'b00, "col_refire_minus1"); tick();
        expect_irq(2'b01, "col_refire"); tick();
        wr(OffAck, 32'd1, 1'b0, "col_clean_ack"); tick();
        tick();
        expect_irq(2'b00, "col_clean"); tick();

        // Disable mid-ACCUM, dropped events, disable-wins, enable-write uses old CTRL
        wr(OffThresh, 32'd10, 1'b0, "wr_thresh10"); tick();
        for (int k = 0; k < 3; k++) begin
            pulse(2'b01); tick();
        end
        rd(32'h28, 64'd3, 1'b0, "dis_cnt3"); tick();
        wr(OffCtrl, 32'd0, 1'b0, "dis_ctrl0"); tick();
        rd(32'h28, 64'd0, 1'b0, "dis_cnt0"); pulse(2'b01); tick();
        rd(32'h28, 64'd0, 1'b0, "dis_dropped"); expect_irq(2'b00, "dis_irq"); tick();
        wr(OffCtrl, 32'd1, 1'b0, "dis_reen"); tick();
        wr(OffCtrl, 32'd0, 1'b0, "dis_wins"); pulse(2'b01); tick();
        rd(32'h28, 64'd0, 1'b0, "dis_wins_cnt"); tick();
        wr(OffCtrl, 32'd1, 1'b0, "en_old_val"); pulse(2'b01); tick();
        rd(32'h28, 64'd0, 1'b0, "en_old_cnt"); tick();

        // Address errors
        rd(32'h38, 64'd0, 1'b1, "unmapped_rd"); tick();
        rd(32'h04, 64'd0, 1'b1, "unaligned_rd"); tick();
        wr(32'h28, 32'd7, 1'b1, "wr_cnt_err"); tick();
        rd(OffAck, 64'd0, 1'b0, "ack_reads0"); tick();

        // Reset mid-ACCUM
        pulse(2'b01); tick();
        pulse(2'b01); tick();
        rd(32'h28, 64'd2, 1'b0, "rst_pre_cnt2"); tick();
        rst_ni = 1'b0;
        expect_irq(2'b00, "rst_accum_irq"); rd(32'h28, 64'd0, 1'b0, "rst_accum_cnt"); tick();
        rst_ni = 1'b1;
        rd(OffCtrl,    64'd0, 1'b0, "rst2_ctrl");    tick();
        rd(OffThresh,  64'd1, 1'b0, "rst2_thresh");  tick();
        rd(OffTimeout, 64'd0, 1'b0, "rst2_timeout"); tick();

        // Reset during FIRE
        wr(OffCtrl, 32'd1, 1'b0, "rf_ctrl1"); tick();
        pulse(2'b01); tick();
        tick();
        expect_irq(2'b01, "rf_fire"); tick();
        rst_ni = 1'b0;
        expect_irq(2'b00, "rf_irq_drop"); rd(OffStatus, 64'd0, 1'b0, "rf_status"); tick();
        rst_ni = 1'b1;
        rd(32'h28,  64'd0, 1'b0, "rf_cnt0"); tick();
        rd(OffCtrl, 64'd0, 1'b0, "rf_ctrl"); tick();
        tick(); tick();

        n_checks++;
        if (q_rsp_name.size() != 0 || q_irq_name.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d rsp and %0d irq expectations left, expected 0 and 0",
                     q_rsp_name.size(), q_irq_name.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
